// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared types and helpers for the SHA-256 result collector.
//   word_t     : one 32-bit SHA-256 word
//   state_t    : eight words, index 7 is the most significant word (a / H0)
//   tag_t      : {valid, nonce} tag carried alongside the round pipeline
//   SHA256_IV  : the standard SHA-256 initial hash value
//   state_add  : word-wise mod-2^32 addition (no carry between words)
//   zero_mask  : mask covering the leading min(zero_bits, 256) digest bits
// -----------------------------------------------------------------------------
package sha256_pkg;

   typedef logic [31:0] word_t;
   typedef word_t [7:0] state_t;

   typedef struct packed {
      logic  valid;
      word_t nonce;
   } tag_t;

   localparam state_t SHA256_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   // Each word wraps on its own; a carry out of one word is discarded.
   function automatic state_t state_add(input state_t a, input state_t b);
      state_t r;
      for (int i = 0; i < 8; i++) begin
         r[i] = a[i] + b[i];
      end
      return r;
   endfunction

   // Ones in the top n bits, n = min(zero_bits, 256). A right shift of an
   // all-ones vector by n leaves n leading zeros; inverting gives the mask.
   // n = 0 yields an empty mask, so every valid job qualifies.
   function automatic logic [255:0] zero_mask(input logic [8:0] zero_bits);
      logic [8:0]   n;
      logic [255:0] ones;
      n    = (zero_bits > 9'd256) ? 9'd256 : zero_bits;
      ones = '1;
      return ~(ones >> n);
   endfunction

endpackage

// File: rtl/sha256_result_fifo.sv
// -----------------------------------------------------------------------------
// sha256_result_fifo
// Synchronous FIFO with a registered head. Push and pop in the same cycle on a
// full FIFO are both accepted (the pop frees the slot first). An empty FIFO
// never forwards push data to the head in the same cycle; it appears one cycle
// later through the head register.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   push, push_data   : write request and data
//   pop               : remove the head (ignored while empty)
//   full, empty       : occupancy flags from the current pointers
//   head_valid        : registered, head entry present
//   head_data         : registered head entry (zero after reset)
// Parameters: WIDTH (entry bits), DEPTH (power of 2, >= 2)
// -----------------------------------------------------------------------------
module sha256_result_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic             head_valid,
   output logic [WIDTH-1:0] head_data
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit: equal indices with different wrap
   // bits means full, identical pointers means empty.
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             head_valid_q, head_valid_d;
   logic [WIDTH-1:0] head_data_q, head_data_d;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   always_comb begin
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop_ok  = pop && !empty;
      push_ok = push && (!full || pop_ok);

      wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_ok  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

      head_valid_d = (wr_ptr_d != rd_ptr_d);
      // The next head is the entry being written right now only when it
      // will be the sole occupant; otherwise it is already in memory.
      if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
         head_data_d = push_data;
      end else begin
         head_data_d = mem[rd_ptr_d[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         head_valid_q <= 1'b0;
         head_data_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         head_valid_q <= head_valid_d;
         head_data_q  <= head_data_d;
      end
   end

   assign head_valid = head_valid_q;
   assign head_data  = head_data_q;

endmodule

// File: rtl/sha256_result_collector.sv
// -----------------------------------------------------------------------------
// sha256_result_collector
// Tail of the 64-stage SHA-256 round pipeline. A tag line follows each job
// through the pipeline, the final round state is added to the midstate to form
// the digest (S1), the digest is tested against a leading-zero difficulty (S2),
// and qualifying nonces are queued in a result FIFO.
// Optional build macro: SHA256_COLLECT_DIGEST_EN -- when defined the FIFO also
// stores the digest and the res_digest port exists.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   issue_valid/issue_nonce : job entering round stage 0 this cycle
//   midstate                : {H0..H7}, stable while jobs are in flight
//   pipe_state              : {a..h} from the final round stage
//   zero_bits               : required leading zero bits (0..256, larger clamps)
//   res_valid/res_ready     : result handshake
//   res_nonce               : nonce of the head result
//   res_digest              : digest of the head result (macro builds only)
//   overflow                : sticky, a hit was dropped on a full FIFO
//   hit_count               : saturating count of results pushed
// Parameters: PIPE_DEPTH (issue-to-pipe_state latency), FIFO_DEPTH (power of 2)
// -----------------------------------------------------------------------------
module sha256_result_collector
   import sha256_pkg::*;
#(
   parameter int PIPE_DEPTH = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         issue_valid,
   input  logic [31:0]  issue_nonce,
   input  logic [255:0] midstate,
   input  logic [255:0] pipe_state,
   input  logic [8:0]   zero_bits,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [31:0]  res_nonce,
`ifdef SHA256_COLLECT_DIGEST_EN
   output logic [255:0] res_digest,
`endif
   output logic         overflow,
   output logic [15:0]  hit_count
);

`ifdef SHA256_COLLECT_DIGEST_EN
   localparam int ENTRY_W = 288;
`else
   localparam int ENTRY_W = 32;
`endif

   // ---------------------------------------------------------------- tag line
   // Stage i holds the job issued i+1 cycles ago, so the last stage lines up
   // with pipe_state. Only the valid bits are reset; stale nonces are inert.
   logic [PIPE_DEPTH-1:0] tag_valid_q, tag_valid_d;
   word_t                 tag_nonce_q [PIPE_DEPTH];
   word_t                 tag_nonce_d [PIPE_DEPTH];

   always_comb begin
      tag_valid_d[0] = issue_valid;
      tag_nonce_d[0] = issue_nonce;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
         tag_valid_d[i] = tag_valid_q[i-1];
         tag_nonce_d[i] = tag_nonce_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
         tag_nonce_q[i] <= tag_nonce_d[i];
      end
      if (reset) begin
         tag_valid_q <= '0;
      end else begin
         tag_valid_q <= tag_valid_d;
      end
   end

   // ---------------------------------------------------------------- S1
   tag_t   s1_tag_q, s1_tag_d;
   state_t s1_digest_q, s1_digest_d;

   always_comb begin
      s1_tag_d.valid = tag_valid_q[PIPE_DEPTH-1];
      s1_tag_d.nonce = tag_nonce_q[PIPE_DEPTH-1];
      s1_digest_d    = state_add(state_t'(pipe_state), state_t'(midstate));
   end

   always_ff @(posedge clk) begin
      s1_digest_q    <= s1_digest_d;
      s1_tag_q.nonce <= s1_tag_d.nonce;
      if (reset) begin
         s1_tag_q.valid <= 1'b0;
      end else begin
         s1_tag_q.valid <= s1_tag_d.valid;
      end
   end

   // ---------------------------------------------------------------- S2 + FIFO
   logic               hit;
   logic               pop;
   logic               push;
   logic               drop;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_head_valid;
   logic [ENTRY_W-1:0] fifo_din;
   logic [ENTRY_W-1:0] fifo_head;
   logic               overflow_q, overflow_d;
   logic [15:0]        hit_count_q, hit_count_d;

   always_comb begin
      hit  = s1_tag_q.valid &&
             ((s1_digest_q & zero_mask(zero_bits)) == 256'd0);
      pop  = fifo_head_valid && res_ready && !fifo_empty;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push = hit && (!fifo_full || pop);
      drop = hit && fifo_full && !pop;

      overflow_d  = overflow_q | drop;
      hit_count_d = (push && (hit_count_q != 16'hFFFF)) ? (hit_count_q + 16'd1)
                                                       : hit_count_q;
   end

`ifdef SHA256_COLLECT_DIGEST_EN
   assign fifo_din = {s1_tag_q.nonce, s1_digest_q};
`else
   assign fifo_din = s1_tag_q.nonce;
`endif

   sha256_result_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_data  (fifo_din),
      .pop        (pop),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .head_valid (fifo_head_valid),
      .head_data  (fifo_head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         hit_count_q <= 16'd0;
      end else begin
         overflow_q  <= overflow_d;
         hit_count_q <= hit_count_d;
      end
   end

   assign res_valid = fifo_head_valid;
   assign overflow  = overflow_q;
   assign hit_count = hit_count_q;
`ifdef SHA256_COLLECT_DIGEST_EN
   assign res_nonce  = fifo_head[287:256];
   assign res_digest = fifo_head[255:0];
`else
   assign res_nonce  = fifo_head;
`endif

endmodule

// File: tb/tb_sha256_result_collector.sv
module tb_sha256_result_collector;

   localparam int PD = 64;
   localparam int FD = 4;
   localparam int NR = 500;

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [223:0] IV_REST = IV[223:0];
   localparam logic [255:0] ALL_F   = {8{32'hffffffff}};
   localparam logic [255:0] ALL_1   = {8{32'h00000001}};
   localparam logic [255:0] PS_W0Z  = {32'h95f61999, 224'd0}; // IV word0 + this = 0

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         issue_valid = 1'b0;
   logic [31:0]  issue_nonce = '0;
   logic [255:0] midstate = '0;
   logic [255:0] pipe_state = '0;
   logic [8:0]   zero_bits = '0;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [31:0]  res_nonce;
`ifdef SHA256_COLLECT_DIGEST_EN
   logic [255:0] res_digest;
`endif
   logic         overflow;
   logic [15:0]  hit_count;

   always #5 clk = ~clk;

   sha256_result_collector #(.PIPE_DEPTH(PD), .FIFO_DEPTH(FD)) dut (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_nonce (issue_nonce),
      .midstate    (midstate),
      .pipe_state  (pipe_state),
      .zero_bits   (zero_bits),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_nonce   (res_nonce),
`ifdef SHA256_COLLECT_DIGEST_EN
      .res_digest  (res_digest),
`endif
      .overflow    (overflow),
      .hit_count   (hit_count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      issue_valid = 1'b0;
      res_ready   = 1'b0;
      reset       = 1'b1;
      step();
      reset       = 1'b0;
   endtask

   task automatic burst(input logic [31:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         issue_valid = 1'b1;
         issue_nonce = first + 32'(i);
         step();
      end
      issue_valid = 1'b0;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, res_valid, 1'b0);
      check({tag, "_nonce"}, res_nonce, 32'd0);
      check({tag, "_ovf"}, overflow, 1'b0);
      check({tag, "_hits"}, hit_count, 16'd0);
`ifdef SHA256_COLLECT_DIGEST_EN
      check({tag, "_digest"}, res_digest, 256'd0);
`endif
   endtask

   // Reference rules: word-wise add, then count leading zeros of the digest.
   function automatic logic [255:0] add_words(input logic [255:0] a, input logic [255:0] b);
      logic [255:0] r;
      for (int w = 0; w < 8; w++) r[w*32 +: 32] = a[w*32 +: 32] + b[w*32 +: 32];
      return r;
   endfunction

   function automatic int lead_zeros(input logic [255:0] d);
      for (int i = 255; i >= 0; i--) if (d[i]) return 255 - i;
      return 256;
   endfunction

   typedef struct {
      logic [255:0] mid;
      logic [255:0] ps;
      logic [8:0]   zb;
      logic [31:0]  nonce;
      bit           exp_hit;
      logic [255:0] exp_digest;
   } vec_t;

   vec_t vecs [10];

   bit           iv_a [NR];
   logic [31:0]  nn_a [NR];
   logic [255:0] ps_a [NR];

   initial begin
      int           exp_hc;
      bit           seen;
      logic [31:0]  q_n [$];
      logic [255:0] q_d [$];
      logic         ovf_m;
      logic [15:0]  hc_m;
      logic [255:0] dg;
      int           j;
      bit           rr;
      int           zbs [3];

      vecs[0] = '{IV,    PS_W0Z,                        9'd32,  32'h1,        1'b1, {32'h0, IV_REST}};
      vecs[1] = '{IV,    PS_W0Z + {32'h1, 224'd0},      9'd32,  32'h2,        1'b0, '0};
      vecs[2] = '{IV,    PS_W0Z + {32'h1, 224'd0},      9'd31,  32'h3,        1'b1, {32'h1, IV_REST}};
      vecs[3] = '{ALL_F, ALL_1,                         9'd256, 32'h4,        1'b1, 256'd0};
      vecs[4] = '{ALL_F, ALL_1,                         9'd300, 32'hdeadbeef, 1'b1, 256'd0};
      vecs[5] = '{IV,    256'd0,                        9'd0,   32'h6,        1'b1, IV};
      vecs[6] = '{IV,    256'd0,                        9'd1,   32'h7,        1'b1, IV};
      vecs[7] = '{IV,    256'd0,                        9'd2,   32'h8,        1'b0, '0};
      vecs[8] = '{ALL_F, {{7{32'h1}}, 32'h2},           9'd256, 32'h9,        1'b0, '0};
      vecs[9] = '{ALL_F, {{7{32'h1}}, 32'h2},           9'd255, 32'ha,        1'b1, {224'd0, 32'h1}};

      // ---------------- reset state
      steps(3);
      reset = 1'b0;
      check_zero_outputs("reset");

      // ---------------- table: one isolated job per vector, exact latency
      exp_hc = 0;
      for (int k = 0; k < 10; k++) begin
         midstate    = vecs[k].mid;
         pipe_state  = vecs[k].ps;
         zero_bits   = vecs[k].zb;
         issue_valid = 1'b1;
         issue_nonce = vecs[k].nonce;
         step();
         issue_valid = 1'b0;
         steps(PD);
         check($sformatf("vec%0d_early", k), res_valid, 1'b0);
         step();
         check($sformatf("vec%0d_valid", k), res_valid, vecs[k].exp_hit);
         if (vecs[k].exp_hit) begin
            exp_hc++;
            check($sformatf("vec%0d_nonce", k), res_nonce, vecs[k].nonce);
`ifdef SHA256_COLLECT_DIGEST_EN
            check($sformatf("vec%0d_digest", k), res_digest, vecs[k].exp_digest);
`endif
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            check($sformatf("vec%0d_popped", k), res_valid, 1'b0);
         end
         check($sformatf("vec%0d_hits", k), hit_count, 16'(exp_hc));
      end

      // ---------------- overflow and order
      do_reset();
      midstate   = IV;
      pipe_state = PS_W0Z;
      zero_bits  = 9'd32;
      burst(32'd10, 6);
      steps(70);
      check("ovf_flag", overflow, 1'b1);
      check("ovf_hits", hit_count, 16'd4);
      res_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("ovf_pop%0d_valid", k), res_valid, 1'b1);
         check($sformatf("ovf_pop%0d_nonce", k), res_nonce, 32'd10 + 32'(k));
         step();
      end
      res_ready = 1'b0;
      check("ovf_drained", res_valid, 1'b0);

      // ---------------- full FIFO with a pop in the push cycle
      do_reset();
      burst(32'd20, 5);
      steps(PD);
      check("fullpop_pre_hits", hit_count, 16'd4);
      check("fullpop_pre_nonce", res_nonce, 32'd20);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("fullpop_ovf", overflow, 1'b0);
      check("fullpop_hits", hit_count, 16'd5);
      res_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("fullpop%0d_valid", k), res_valid, 1'b1);
         check($sformatf("fullpop%0d_nonce", k), res_nonce, 32'd21 + 32'(k));
         step();
      end
      res_ready = 1'b0;
      check("fullpop_empty", res_valid, 1'b0);

      // ---------------- reset with a job in flight and a non-empty FIFO
      burst(32'd30, 6);
      steps(70);
      check("rst_pre_ovf", overflow, 1'b1);
      check("rst_pre_valid", res_valid, 1'b1);
      burst(32'd5, 1);
      steps(9);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_zero_outputs("rst_mid");
      seen = 1'b0;
      for (int k = 0; k < PD + 16; k++) begin
         step();
         if (res_valid) seen = 1'b1;
      end
      check("rst_job_lost", seen, 1'b0);

      // ---------------- randomized run against a queue model
      zbs = '{0, 1, 3};
      for (int ph = 0; ph < 3; ph++) begin
         do_reset();
         for (int w = 0; w < 8; w++) midstate[w*32 +: 32] = $urandom();
         zero_bits = 9'(zbs[ph]);
         for (int c = 0; c < NR; c++) begin
            iv_a[c] = (c < NR - PD - 12) && ($urandom_range(0, 9) < 8);
            nn_a[c] = $urandom();
            for (int w = 0; w < 8; w++) ps_a[c][w*32 +: 32] = $urandom();
         end
         q_n.delete();
         q_d.delete();
         ovf_m = 1'b0;
         hc_m  = 16'd0;
         for (int c = 0; c < NR; c++) begin
            issue_valid = iv_a[c];
            issue_nonce = nn_a[c];
            if (c >= PD) pipe_state = ps_a[c-PD];
            else for (int w = 0; w < 8; w++) pipe_state[w*32 +: 32] = $urandom();
            rr = 1'($urandom_range(0, 1));
            res_ready = rr;

            check($sformatf("rnd%0d_c%0d_valid", ph, c), res_valid, q_n.size() > 0);
            if (q_n.size() > 0) begin
               check($sformatf("rnd%0d_c%0d_nonce", ph, c), res_nonce, q_n[0]);
`ifdef SHA256_COLLECT_DIGEST_EN
               check($sformatf("rnd%0d_c%0d_digest", ph, c), res_digest, q_d[0]);
`endif
            end
            check($sformatf("rnd%0d_c%0d_ovf", ph, c), overflow, ovf_m);
            check($sformatf("rnd%0d_c%0d_hits", ph, c), hit_count, hc_m);

            // Effect of the coming edge: pop first, then the job issued
            // PD+1 cycles ago reaches the FIFO.
            if (q_n.size() > 0 && rr) begin
               void'(q_n.pop_front());
               void'(q_d.pop_front());
            end
            j = c - PD - 1;
            if (j >= 0 && iv_a[j]) begin
               dg = add_words(ps_a[j], midstate);
               if (lead_zeros(dg) >= ((zbs[ph] > 256) ? 256 : zbs[ph])) begin
                  if (q_n.size() < FD) begin
                     q_n.push_back(nn_a[j]);
                     q_d.push_back(dg);
                     if (hc_m != 16'hffff) hc_m = hc_m + 16'd1;
                  end else begin
                     ovf_m = 1'b1;
                  end
               end
            end
            step();
         end
         issue_valid = 1'b0;
         res_ready   = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sha256_result_collector.md
# sha256_result_collector

Consumer end of the 64-stage SHA-256 round pipeline. It tracks which nonce is in flight alongside the pipeline, adds the midstate to the final round state to form the digest, and tests the digest against a leading-zero difficulty. Qualifying nonces are queued in a small result FIFO with a valid/ready output. It sits between the last round stage and the host/work-control logic.

## Interface
- `PIPE_DEPTH`, default 64: cycles from a job entering round stage 0 to its final state appearing at `pipe_state`.
- `FIFO_DEPTH`, default 4: result FIFO entries; must be a power of 2, ≥2.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `issue_valid` in 1: a job entered round stage 0 this cycle.
- `issue_nonce` in 32: nonce of that job.
- `midstate` in 256: {H0..H7}, MSB word first; quasi-static, changed only when no job is in flight.
- `pipe_state` in 256: {a..h} from the final round stage, MSB word first.
- `zero_bits` in 9: required leading zero bits of the digest, 0..256.
- `res_valid` out 1: FIFO head is valid.
- `res_ready` in 1: consumer accepts the head.
- `res_nonce` out 32: nonce of the head entry.
- `res_digest` out 256: digest of the head entry; present only with `SHA256_COLLECT_DIGEST_EN`.
- `overflow` out 1: sticky; a hit was dropped because the FIFO was full.
- `hit_count` out 16: saturating count of hits pushed.

## Operation
- **Tag line:** `PIPE_DEPTH`-entry shift register of {valid, nonce}, loaded from `issue_*` every cycle. Its output is aligned with `pipe_state`.
- **S1 (register):** `digest[i] = pipe_state[i] + midstate[i]` per 32-bit word, mod 2^32, no carry between words. The tag is registered alongside.
- **S2:** `hit = tag_valid && digest[255 -: n] == 0`.
  - `n = min(zero_bits, 256)`.
  - `zero_bits == 0` makes every valid job a hit.
- **Push:** on a hit when not full, or when full and a pop occurs in the same cycle (pop frees the slot first). A hit while full with no pop is dropped and sets `overflow`. `hit_count` increments on push only and saturates at 0xFFFF.
- **Pop:** on `res_valid && res_ready`. FIFO order is strict FIFO.
- **Empty:** simultaneous push and pop behaves as a push only; the head is not bypassed combinationally.
- **Wrap-around:** pointers are log2(FIFO_DEPTH)+1 bits; full/empty is derived from the MSB compare.
- **Reset:** clears tag-line valids, S1/S2 valids, FIFO pointers, `overflow` and `hit_count`. In-flight jobs are lost. Round-pipeline contents are not reset and are ignored because their tags are invalid.

## Timing
- Job issued in cycle t → `pipe_state` valid in cycle t+PIPE_DEPTH → S1 registered at the end of that cycle → S2 compare and FIFO push at the end of cycle t+PIPE_DEPTH+1.
- `res_valid` is first high in cycle t+PIPE_DEPTH+2 (66 with defaults).
- Sustains one issue per cycle; no backpressure toward the pipeline.
- Values after reset: `res_valid`=0, `res_nonce`=0, `res_digest`=0, `overflow`=0, `hit_count`=0.
- All outputs are registered.

## Configuration
- `SHA256_COLLECT_DIGEST_EN` defined: the FIFO stores {nonce, digest} (288 bits/entry) and the `res_digest` port exists.
- Undefined: the FIFO stores the nonce only, `res_digest` is absent, and the digest is used solely for the compare.

## Structure
- `sha256_pkg` holds:
  - `word_t` (32-bit) and `state_t` (8×`word_t`) typedefs.
  - The SHA-256 IV constants.
  - A `state_add` function for word-wise mod-2^32 addition.
- One sub-module, `sha256_result_fifo`: parameterized width/depth, synchronous FIFO with push/pop/full/empty and registered head.

## Test plan
- **Single hit:** `midstate`=IV, `pipe_state` chosen so digest word 0 = 0x00000000, `zero_bits`=32, issue nonce 0x00000001 → `res_valid` exactly 66 cycles later, `res_nonce`=0x00000001, `hit_count`=1.
- **Threshold:** digest word 0 = 0x00000001 → no result at `zero_bits`=32. Same job at `zero_bits`=31 → hit.
- **Per-word wrap:** all `midstate` words 0xFFFFFFFF, all `pipe_state` words 0x00000001 → `res_digest` = all zero (no inter-word carry). With `zero_bits`=256 → hit.
- **Overflow and order:** `res_ready`=0, six back-to-back hits with nonces 10..15 → FIFO holds 10..13, `overflow`=1, `hit_count`=4. Then `res_ready`=1 → pops 10, 11, 12, 13 in order, `res_valid`=0 afterward.
- **Full with simultaneous pop:** FIFO full, `res_ready`=1 in the same cycle as a hit push → push accepted, `overflow` stays 0, count stays at 4 entries.
- **Reset mid-flight:** issue nonce 0x5 at t, assert `reset` at t+10 for one cycle → no `res_valid` for 0x5 ever; all outputs read 0 the cycle after reset.
